// File: rtl/muit.sv
// muit: two-stage pipelined 8x8 unsigned multiplier (partial products + adder tree).
// Ports: clk, rst (async active-high), a/b 8-bit operands, outcome 16-bit product.
module muit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] outcome
);

  // Reset is applied asynchronously but released on the falling clk edge,
  // half a period clear of the rising edge that samples the operands, so
  // the rising edge after release is the first sampling edge.
  logic rst_hold;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) rst_hold <= 1'b1;
    else     rst_hold <= 1'b0;
  end

  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [15:0] pp [8];
  logic [15:0] s1 [4];
  logic [15:0] s2 [2];
  logic [15:0] s3;

  always_ff @(posedge clk or posedge rst_hold) begin
    if (rst_hold) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      a_r <= a;
      b_r <= b;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = '0;
      if (b_r[i]) pp[i] = {8'b0, a_r} << i;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) s1[i] = pp[2*i] + pp[2*i+1];
    for (int i = 0; i < 2; i++) s2[i] = s1[2*i] + s1[2*i+1];
    s3 = s2[0] + s2[1];
  end

  always_ff @(posedge clk or posedge rst_hold) begin
    if (rst_hold) outcome <= '0;
    else          outcome <= s3;
  end

endmodule

// File: tb/tb_muit.sv
// tb_muit: table, streaming, reset and random checks for muit.
// Expected values come from plain integer products and a history queue.
module tb_muit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic [15:0] outcome;

  muit dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .outcome(outcome)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int unsigned hist[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(string nm, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (a=%0d b=%0d t=%0t)",
               nm, act, exp, a, b, $time);
    end
  endtask

  // One rising edge; the model records what that edge samples.
  task automatic tick();
    hist.push_back(int'(a) * int'(b));
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned model_out();
    return hist[hist.size()-2];
  endfunction

  initial begin
    vec_t vt[$];
    int unsigned prev;
    int unsigned st[4];

    for (int n = 1; n <= 12; n++)
      vt.push_back('{a: 8'(n), b: 8'(n), exp: 16'(n*n)});
    vt.push_back('{a: 8'd8,   b: 8'd8,   exp: 16'd64});
    vt.push_back('{a: 8'd255, b: 8'd255, exp: 16'hFE01});
    vt.push_back('{a: 8'd255, b: 8'd0,   exp: 16'd0});
    vt.push_back('{a: 8'd0,   b: 8'd200, exp: 16'd0});
    vt.push_back('{a: 8'd1,   b: 8'd255, exp: 16'd255});
    vt.push_back('{a: 8'd128, b: 8'd2,   exp: 16'd256});

    // Reset held with nonzero operands and the clock running.
    rst = 1'b1;
    a = 8'h37;
    b = 8'h55;
    #2;
    chk("reset_t0", outcome, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", outcome, 0);
    end
    a = 8'd0;
    b = 8'd0;
    rst = 1'b0;
    hist = '{0};

    // Table: each vector held 10 clocks; old value lasts one more edge.
    prev = 0;
    foreach (vt[i]) begin
      a = vt[i].a;
      b = vt[i].b;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (k == 1) chk("tbl_latency", outcome, prev);
        else        chk("tbl_value", outcome, vt[i].exp);
      end
      prev = vt[i].exp;
    end

    // Back-to-back operands every cycle.
    st = '{12, 30, 56, 90};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        a = 8'(3 + 2*i);
        b = 8'(4 + 2*i);
      end
      tick();
      if (i == 0) chk("stream_first", outcome, prev);
      else        chk("stream", outcome, st[i-1]);
    end

    // Mid-stream reset drops in-flight data.
    a = 8'd10;
    b = 8'd10;
    tick();
    tick();
    chk("pre_rst", outcome, 100);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", outcome, 0);
    a = 8'd11;
    b = 8'd11;
    tick();
    chk("rst_edge", outcome, 0);
    rst = 1'b0;
    hist = '{0};
    tick();
    chk("rel_edge1", outcome, 0);
    tick();
    chk("rel_edge2", outcome, 121);

    // Random stream against the history model.
    for (int i = 0; i < 10000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      tick();
      chk("random", outcome, model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
